// File: rtl/ts_sched.sv
`default_nettype none
// ============================================================================
// Module      : ts_sched
// Description : Transmit scheduler. Accepts per-queue eligibility pulses from
//               gate control, grants one queue by strict priority
//               (Q0 > Q1 > Q2 > Q3), pops that queue's descriptor from the
//               memory block (MB) and hands it to the egress buffer manager
//               (EBM). No new grant is taken until EBM reports the packet
//               sent, or until the wait timeout expires.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   PLATFORM     target vendor string; no functional effect
//   TIMEOUT_CYC  max cycles spent waiting for pkt_done (12-bit range)
// Configuration macro
//   TS_STATS_EN  when defined, adds out_ts_grant_cnt (4 x 32-bit counters)
// Ports
//   clk                   in   1   system clock
//   rst_n                 in   1   asynchronous active-low reset
//   in_ts_schedule_valid  in   4   bit i = Qi eligible (1-cycle pulse)
//   out_ts_desc_rden      out  4   bit i = pop Qi descriptor (1-cycle pulse)
//   in_ts_desc_data       in  64   Qi descriptor in [16i+15:16i], 1 cycle
//                                  after rden; {outport, pkt_len[6:0], buf_id}
//   out_ts_q2_rden        out  1   copy of out_ts_desc_rden[2]
//   out_ts_desc_wr        out  1   descriptor strobe to EBM
//   out_ts_bufid          out  8   buffer id
//   out_ts_outport        out  1   output port select
//   out_ts_pkt_len        out  7   packet length in 16-byte units
//   in_ts_ebm_ready       in   1   EBM accepts descriptor when high with wr
//   in_ts_pkt_done        in   1   packet transmission finished (pulse)
//   out_ts_err            out  1   sticky: grant dropped while busy / timeout
//   out_ts_grant_cnt      out 128  (TS_STATS_EN only) Qi count in [32i+31:32i]
// ============================================================================
module ts_sched #(
  parameter PLATFORM    = "xilinx",
  parameter TIMEOUT_CYC = 4095
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  in_ts_schedule_valid,
  output logic [3:0]  out_ts_desc_rden,
  input  logic [63:0] in_ts_desc_data,
  output logic        out_ts_q2_rden,
  output logic        out_ts_desc_wr,
  output logic [7:0]  out_ts_bufid,
  output logic        out_ts_outport,
  output logic [6:0]  out_ts_pkt_len,
  input  logic        in_ts_ebm_ready,
  input  logic        in_ts_pkt_done,
  output logic        out_ts_err
`ifdef TS_STATS_EN
  ,
  output logic [127:0] out_ts_grant_cnt
`endif
);

  // --------------------------------------------------------------------------
  // Constants and types
  // --------------------------------------------------------------------------
  localparam logic [12:0] c_TIMEOUT    = 13'(TIMEOUT_CYC);
  localparam logic [11:0] c_TIMEOUT_12 = 12'(TIMEOUT_CYC);

  typedef enum logic [1:0] {
    IDLE_S  = 2'd0,
    RD_S    = 2'd1,
    ISSUE_S = 2'd2,
    WAIT_S  = 2'd3
  } state_e;

  // --------------------------------------------------------------------------
  // Vendor hook: PLATFORM selects nothing functional today; the labelled
  // blocks give a place to attach vendor-specific primitives later.
  // --------------------------------------------------------------------------
  generate
    if (PLATFORM == "xilinx") begin : g_plat_xilinx
    end else begin : g_plat_generic
    end
  endgenerate

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  state_e      state_q, state_d;
  logic [1:0]  sel_q, sel_d;
  logic [3:0]  desc_rden_q, desc_rden_d;
  logic [7:0]  bufid_q, bufid_d;
  logic        outport_q, outport_d;
  logic [6:0]  pkt_len_q, pkt_len_d;
  logic [11:0] cnt_q, cnt_d;
  logic        err_q, err_d;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic [1:0]  w_pri_sel;
  logic [15:0] w_desc;
  logic [12:0] w_cnt_inc;
  logic        w_tmo_hit;

  // Strict priority: lowest-numbered eligible queue wins.
  always_comb begin
    w_pri_sel = 2'd3;
    if (in_ts_schedule_valid[0])      w_pri_sel = 2'd0;
    else if (in_ts_schedule_valid[1]) w_pri_sel = 2'd1;
    else if (in_ts_schedule_valid[2]) w_pri_sel = 2'd2;
  end

  // Descriptor lane of the granted queue.
  always_comb begin
    w_desc = in_ts_desc_data[15:0];
    case (sel_q)
      2'd0:    w_desc = in_ts_desc_data[15:0];
      2'd1:    w_desc = in_ts_desc_data[31:16];
      2'd2:    w_desc = in_ts_desc_data[47:32];
      default: w_desc = in_ts_desc_data[63:48];
    endcase
  end

  // The counter is compared after increment so that the timeout fires on the
  // TIMEOUT_CYC-th wait cycle; the wide compare also keeps TIMEOUT_CYC=0 sane.
  assign w_cnt_inc = {1'b0, cnt_q} + 13'd1;
  assign w_tmo_hit = (w_cnt_inc >= c_TIMEOUT);

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    desc_rden_d = 4'b0000;
    bufid_d     = bufid_q;
    outport_d   = outport_q;
    pkt_len_d   = pkt_len_q;
    cnt_d       = cnt_q;
    err_d       = err_q;

    // A grant arriving while a transfer is in flight is dropped and flagged.
    if ((state_q != IDLE_S) && (in_ts_schedule_valid != 4'b0000)) begin
      err_d = 1'b1;
    end

    case (state_q)
      IDLE_S: begin
        if (in_ts_schedule_valid != 4'b0000) begin
          sel_d       = w_pri_sel;
          desc_rden_d = 4'b0001 << w_pri_sel;
          state_d     = RD_S;
        end
      end

      // RD_S spans two cycles: the first carries the pop strobe, the second
      // is when MB presents the descriptor, which is captured here.
      RD_S: begin
        if (desc_rden_q == 4'b0000) begin
          outport_d = w_desc[15];
          pkt_len_d = w_desc[14:8];
          bufid_d   = w_desc[7:0];
          state_d   = ISSUE_S;
        end
      end

      ISSUE_S: begin
        if (in_ts_ebm_ready) begin
          cnt_d   = 12'd0;
          state_d = WAIT_S;
        end
      end

      WAIT_S: begin
        // pkt_done takes precedence over a simultaneous timeout.
        if (in_ts_pkt_done) begin
          state_d = IDLE_S;
        end else if (w_tmo_hit) begin
          cnt_d   = c_TIMEOUT_12;
          err_d   = 1'b1;
          state_d = IDLE_S;
        end else begin
          cnt_d = w_cnt_inc[11:0];
        end
      end

      default: begin
        state_d = IDLE_S;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE_S;
      sel_q       <= 2'd0;
      desc_rden_q <= 4'b0000;
      bufid_q     <= 8'd0;
      outport_q   <= 1'b0;
      pkt_len_q   <= 7'd0;
      cnt_q       <= 12'd0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      desc_rden_q <= desc_rden_d;
      bufid_q     <= bufid_d;
      outport_q   <= outport_d;
      pkt_len_q   <= pkt_len_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  // desc_wr is decoded from state so an asynchronous reset drops it at once.
  assign out_ts_desc_rden = desc_rden_q;
  assign out_ts_q2_rden   = desc_rden_q[2];
  assign out_ts_desc_wr   = (state_q == ISSUE_S);
  assign out_ts_bufid     = bufid_q;
  assign out_ts_outport   = outport_q;
  assign out_ts_pkt_len   = pkt_len_q;
  assign out_ts_err       = err_q;

  // --------------------------------------------------------------------------
  // Optional per-queue grant statistics (free-running, wrap at 2^32)
  // --------------------------------------------------------------------------
`ifdef TS_STATS_EN
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_grant_cnt
      logic [31:0] grant_cnt_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          grant_cnt_q <= 32'd0;
        end else if (desc_rden_q[gi]) begin
          grant_cnt_q <= grant_cnt_q + 32'd1;
        end
      end

      assign out_ts_grant_cnt[32*gi +: 32] = grant_cnt_q;
    end
  endgenerate
`endif

endmodule

`default_nettype wire
